// File: rtl/jedro_1_core.sv
// jedro_1_core: three-stage RV32I-subset core (fetch, decode, execute/writeback).
// Executes LUI, OP-IMM and OP instructions. Any other encoding latches a sticky
// halt flag that freezes fetch. The data port is tied off.

package jedro_1_pkg;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// Instruction decoder: field extraction, immediate generation and legality check.
module jedro_1_decoder
   import jedro_1_pkg::*;
(
   input  logic [31:0] instr,
   output logic        illegal,
   output logic        reg_we,
   output logic        use_imm,
   output alu_op_e     alu_op,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Decode the opcode class, then qualify funct3/funct7 within it.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      illegal = 1'b1;
      reg_we  = 1'b0;
      use_imm = 1'b0;
      alu_op  = ALU_ADD;
      rd      = instr[11:7];
      rs1     = instr[19:15];
      rs2     = instr[24:20];
      imm     = {{20{instr[31]}}, instr[31:20]};

      case (opcode)
         OPC_LUI: begin
            // LUI is rd = x0 + U-immediate.
            illegal = 1'b0;
            reg_we  = 1'b1;
            use_imm = 1'b1;
            rs1     = 5'd0;
            imm     = {instr[31:12], 12'b0};
         end

         OPC_OP_IMM: begin
            illegal = 1'b0;
            reg_we  = 1'b1;
            use_imm = 1'b1;
            case (funct3)
               3'b000: alu_op = ALU_ADD;
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               3'b110: alu_op = ALU_OR;
               3'b111: alu_op = ALU_AND;
               3'b001: begin
                  alu_op  = ALU_SLL;
                  illegal = (funct7 != F7_BASE);
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                  else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                  else                       illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end

         OPC_OP: begin
            illegal = 1'b0;
            reg_we  = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'b000:  alu_op = ALU_ADD;
                  3'b001:  alu_op = ALU_SLL;
                  3'b010:  alu_op = ALU_SLT;
                  3'b011:  alu_op = ALU_SLTU;
                  3'b100:  alu_op = ALU_XOR;
                  3'b101:  alu_op = ALU_SRL;
                  3'b110:  alu_op = ALU_OR;
                  default: alu_op = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               alu_op = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               alu_op = ALU_SRA;
            end else begin
               illegal = 1'b1;
            end
         end

         default: illegal = 1'b1;
      endcase

      if (illegal) reg_we = 1'b0;
   end

endmodule

// 32-entry register file: two combinational read ports, one write port, x0 hardwired to 0.
module jedro_1_regfile #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [4:0]            rs1_addr,
   input  logic [4:0]            rs2_addr,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  we,
   input  logic [4:0]            rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] regfile [32];

   // Clear all registers on reset; otherwise write rd unless it is x0.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         // NOTE: this array is explicitly reset, so it maps to flops rather than a RAM macro.
         for (int i = 0; i < 32; i++) regfile[i] <= '0;
      end else if (we && rd_addr != 5'd0) begin
         regfile[rd_addr] <= rd_data;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0) ? '0 : regfile[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 : regfile[rs2_addr];

endmodule

// Core top: PC/fetch, decode with EX-result forwarding, execute and writeback.
module jedro_1_core
   import jedro_1_pkg::*;
#(
   parameter int                DATA_WIDTH = 32,
   parameter int                ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   output logic [ADDR_WIDTH-1:0]   instr_addr_o,
   input  logic [DATA_WIDTH-1:0]   instr_rdata_i,
   output logic [ADDR_WIDTH-1:0]   data_addr_o,
   output logic [DATA_WIDTH-1:0]   data_wdata_o,
   output logic [DATA_WIDTH/8-1:0] data_we_o,
   input  logic [DATA_WIDTH-1:0]   data_rdata_i,
   output logic                    illegal_instr_o
);

   // Fetch state
   logic [ADDR_WIDTH-1:0] pc;
   logic                  fetch_valid;
   logic                  illegal_instr_ro;

   // Decode stage
   logic                  id_valid;
   logic                  id_illegal;
   logic                  id_reg_we;
   logic                  id_use_imm;
   alu_op_e               id_alu_op;
   logic [4:0]            id_rd;
   logic [4:0]            id_rs1;
   logic [4:0]            id_rs2;
   logic [31:0]           id_imm;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic [DATA_WIDTH-1:0] id_op_a;
   logic [DATA_WIDTH-1:0] id_rs2_val;
   logic [DATA_WIDTH-1:0] id_op_b;

   // Execute stage
   logic                  ex_valid;
   logic                  ex_we;
   alu_op_e               ex_alu_op;
   logic [4:0]            ex_rd;
   logic [DATA_WIDTH-1:0] ex_a;
   logic [DATA_WIDTH-1:0] ex_b;
   logic [DATA_WIDTH-1:0] ex_result;
   logic                  ex_fwd_ok;

   logic unused_data;
   assign unused_data = ^data_rdata_i;

   // The word on instr_rdata_i belongs to the previous cycle's fetch; once halted, it is squashed.
   assign id_valid = fetch_valid && !illegal_instr_ro;

   jedro_1_decoder decoder_inst (
      .instr   (instr_rdata_i),
      .illegal (id_illegal),
      .reg_we  (id_reg_we),
      .use_imm (id_use_imm),
      .alu_op  (id_alu_op),
      .rd      (id_rd),
      .rs1     (id_rs1),
      .rs2     (id_rs2),
      .imm     (id_imm)
   );

   jedro_1_regfile #(.DATA_WIDTH(DATA_WIDTH)) regfile_inst (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .rs1_addr (id_rs1),
      .rs2_addr (id_rs2),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .we       (ex_valid && ex_we),
      .rd_addr  (ex_rd),
      .rd_data  (ex_result)
   );

   // An instruction in EX that will write a non-zero rd supplies its result to ID directly.
   assign ex_fwd_ok  = ex_valid && ex_we && (ex_rd != 5'd0);
   assign id_op_a    = (ex_fwd_ok && ex_rd == id_rs1) ? ex_result : rs1_data;
   assign id_rs2_val = (ex_fwd_ok && ex_rd == id_rs2) ? ex_result : rs2_data;
   assign id_op_b    = id_use_imm ? id_imm : id_rs2_val;

   // ALU: 32-bit wrap-around arithmetic; shifts use the low 5 bits of operand B.
   always_comb begin
      ex_result = '0;
      case (ex_alu_op)
         ALU_ADD:  ex_result = ex_a + ex_b;
         ALU_SUB:  ex_result = ex_a - ex_b;
         ALU_SLL:  ex_result = ex_a << ex_b[4:0];
         ALU_SLT:  ex_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
         ALU_SLTU: ex_result = {{(DATA_WIDTH-1){1'b0}}, (ex_a < ex_b)};
         ALU_XOR:  ex_result = ex_a ^ ex_b;
         ALU_SRL:  ex_result = ex_a >> ex_b[4:0];
         ALU_SRA:  ex_result = $unsigned($signed(ex_a) >>> ex_b[4:0]);
         ALU_OR:   ex_result = ex_a | ex_b;
         ALU_AND:  ex_result = ex_a & ex_b;
         default:  ex_result = '0;
      endcase
   end

   // Pipeline registers: PC advance, halt flag and the ID->EX stage.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rstn_i) begin
         pc               <= BOOT_ADDR;
         fetch_valid      <= 1'b0;
         illegal_instr_ro <= 1'b0;
         ex_valid         <= 1'b0;
         ex_we            <= 1'b0;
         ex_alu_op        <= ALU_ADD;
         ex_rd            <= '0;
         ex_a             <= '0;
         ex_b             <= '0;
      end else begin
         if (!illegal_instr_ro) pc <= pc + ADDR_WIDTH'(4);
         fetch_valid <= 1'b1;
         if (id_valid && id_illegal) illegal_instr_ro <= 1'b1;
         ex_valid  <= id_valid && !id_illegal;
         ex_we     <= id_reg_we;
         ex_alu_op <= id_alu_op;
         ex_rd     <= id_rd;
         ex_a      <= id_op_a;
         ex_b      <= id_op_b;
      end
   end

   assign instr_addr_o    = pc;
   assign illegal_instr_o = illegal_instr_ro;
   assign data_addr_o     = '0;
   assign data_wdata_o    = '0;
   assign data_we_o       = '0;

endmodule

// File: tb/tb_jedro_1_core.sv
// Directed testbench for jedro_1_core: small programs in a synchronous ROM model,
// register and fetch-address checks against hand-computed values.

module tb_jedro_1_core;

   logic        clk;
   logic        rstn_i;
   logic [31:0] instr_addr_o;
   logic [31:0] instr_rdata_i;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic [3:0]  data_we_o;
   logic [31:0] data_rdata_i;
   logic        illegal_instr_o;

   int vectors     = 0;
   int miscompares = 0;
   int data_bad    = 0;

   logic [31:0] rom [0:63];

   jedro_1_core dut (
      .clk_i           (clk),
      .rstn_i          (rstn_i),
      .instr_addr_o    (instr_addr_o),
      .instr_rdata_i   (instr_rdata_i),
      .data_addr_o     (data_addr_o),
      .data_wdata_o    (data_wdata_o),
      .data_we_o       (data_we_o),
      .data_rdata_i    (data_rdata_i),
      .illegal_instr_o (illegal_instr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: word for the address presented in one cycle appears in the next.
   always @(posedge clk) instr_rdata_i <= rom[instr_addr_o[7:2]];

   // The data port must stay idle at all times.
   always @(negedge clk)
      if (data_we_o !== 4'h0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) data_bad++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rf(input int idx);
      return dut.regfile_inst.regfile[idx];
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'h37};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
   endtask

   // Hold reset for two edges; returns in the first cycle with rstn_i high.
   task automatic do_reset();
      @(negedge clk);
      rstn_i = 1'b0;
      repeat (2) @(negedge clk);
      rstn_i = 1'b1;
   endtask

   // Wait (bounded) for the halt flag, then check the frozen fetch address.
   task automatic run_to_halt(input string tag, input logic [31:0] exp_pc);
      int n;
      n = 0;
      while (illegal_instr_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_flag"}, {31'b0, illegal_instr_o}, 32'd1);
      check({tag, "_pc_at_halt"}, instr_addr_o, exp_pc);
      repeat (3) @(negedge clk);
      check({tag, "_pc_frozen"}, instr_addr_o, exp_pc);
      check({tag, "_flag_sticky"}, {31'b0, illegal_instr_o}, 32'd1);
   endtask

   task automatic load_shift_chain();
      clear_rom();
      rom[0] = enc_i(12'd64, 5'd0, 3'b000, 5'd1);  // ADDI x1,x0,64
      rom[1] = enc_i(12'd1,  5'd1, 3'b101, 5'd2);  // SRLI x2,x1,1
      rom[2] = enc_i(12'd2,  5'd2, 3'b101, 5'd2);  // SRLI x2,x2,2
      rom[3] = enc_i(12'd3,  5'd2, 3'b101, 5'd3);  // SRLI x3,x2,3
   endtask

   initial begin
      rstn_i       = 1'b0;
      data_rdata_i = 32'hDEAD_BEEF;
      clear_rom();

      // Shift chain, plus reset-state and first-fetch checks.
      load_shift_chain();
      do_reset();
      check("rst_pc", instr_addr_o, 32'h0);
      check("rst_flag", {31'b0, illegal_instr_o}, 32'd0);
      check("rst_x5", rf(5), 32'h0);
      check("rst_x31", rf(31), 32'h0);
      @(negedge clk);
      check("pc_step", instr_addr_o, 32'h4);
      run_to_halt("shift", 32'd24);
      check("shift_x1", rf(1), 32'd64);
      check("shift_x2", rf(2), 32'd8);
      check("shift_x3", rf(3), 32'd1);

      // Back-to-back forwarding.
      clear_rom();
      rom[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);                 // ADDI x1,x0,5
      rom[1] = enc_i(12'd7, 5'd1, 3'b000, 5'd1);                 // ADDI x1,x1,7
      rom[2] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);      // ADD x2,x1,x1
      do_reset();
      check("fwd_rst_x3", rf(3), 32'h0);
      run_to_halt("fwd", 32'd20);
      check("fwd_x1", rf(1), 32'd12);
      check("fwd_x2", rf(2), 32'd24);

      // Signed immediates and signed/unsigned comparisons.
      clear_rom();
      rom[0] = enc_i(12'hFF0, 5'd0, 3'b000, 5'd1);               // ADDI x1,x0,-16
      rom[1] = enc_i(12'h402, 5'd1, 3'b101, 5'd2);               // SRAI x2,x1,2
      rom[2] = enc_i(12'd28,  5'd1, 3'b101, 5'd3);               // SRLI x3,x1,28
      rom[3] = enc_i(12'd0,   5'd1, 3'b010, 5'd4);               // SLTI x4,x1,0
      rom[4] = enc_i(12'd1,   5'd1, 3'b011, 5'd5);               // SLTIU x5,x1,1
      do_reset();
      run_to_halt("sgn", 32'd28);
      check("sgn_x1", rf(1), 32'hFFFF_FFF0);
      check("sgn_x2", rf(2), 32'hFFFF_FFFC);
      check("sgn_x3", rf(3), 32'h0000_000F);
      check("sgn_x4", rf(4), 32'd1);
      check("sgn_x5", rf(5), 32'd0);

      // x0 is never written; LUI result forwards into ORI.
      clear_rom();
      rom[0] = enc_lui(20'h12345, 5'd0);                         // LUI x0,0x12345
      rom[1] = enc_lui(20'hABCDE, 5'd6);                         // LUI x6,0xABCDE
      rom[2] = enc_i(12'h123, 5'd6, 3'b110, 5'd6);               // ORI x6,x6,0x123
      do_reset();
      run_to_halt("lui", 32'd20);
      check("lui_x0", rf(0), 32'h0);
      check("lui_x6", rf(6), 32'hABCD_E123);

      // Illegal word halts; the instruction after it never writes back.
      clear_rom();
      rom[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1);                 // ADDI x1,x0,1
      rom[1] = 32'hFFFF_FFFF;
      rom[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd1);                 // ADDI x1,x0,2
      do_reset();
      run_to_halt("ill", 32'd12);
      check("ill_x1", rf(1), 32'd1);

      // Reset in the middle of the shift chain.
      load_shift_chain();
      do_reset();
      repeat (4) @(negedge clk);
      check("mid_x1_before", rf(1), 32'd64);
      rstn_i = 1'b0;
      @(negedge clk);
      check("mid_rst_x1", rf(1), 32'h0);
      check("mid_rst_x2", rf(2), 32'h0);
      check("mid_rst_pc", instr_addr_o, 32'h0);
      check("mid_rst_flag", {31'b0, illegal_instr_o}, 32'd0);
      rstn_i = 1'b1;
      run_to_halt("mid", 32'd24);
      check("mid_x1", rf(1), 32'd64);
      check("mid_x3", rf(3), 32'd1);

      check("data_port_idle", data_bad, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jedro_1_core.md
# jedro_1_core

RV32I-subset integer core for the jedro_1 family: a three-stage in-order pipeline (fetch, decode, execute/writeback) that fetches from a synchronous read-only instruction memory and executes register-immediate, register-register and LUI instructions. It sits between the instruction ROM wrapper and the byte-write data RAM wrapper at the top of the SoC. The data port is present for interface compatibility but idle in this scope. Any unsupported encoding halts the core.

## Interface
- DATA_WIDTH, 32, data/instruction word width (only 32 supported)
- ADDR_WIDTH, 32, memory address width
- BOOT_ADDR, 32'h0, first fetch address after reset
- clk_i  in  1  single clock, all state on rising edge
- rstn_i  in  1  reset; synchronous, active-low
- instr_addr_o  out  ADDR_WIDTH  byte address to instruction ROM (word-aligned)
- instr_rdata_i  in  DATA_WIDTH  ROM word, valid one cycle after address
- data_addr_o  out  ADDR_WIDTH  data RAM address, constant 0
- data_wdata_o  out  DATA_WIDTH  constant 0
- data_we_o  out  DATA_WIDTH/8  byte write enables, constant 0
- data_rdata_i  in  DATA_WIDTH  ignored
- illegal_instr_o  out  1  sticky halt flag

## Operation
- Supported: LUI; OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI); OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Illegal: any other opcode, bad funct3/funct7, shift-immediate with imm[11:5] not 0000000 (SRAI: 0100000), all-zero word.
- Register file: 32x32, x0 reads 0, writes to x0 dropped. All registers reset to 0. Instance name regfile_inst, array regfile.
- Decoder instance name decoder_inst. Registered illegal flag illegal_instr_ro drives illegal_instr_o.
- Arithmetic: 32-bit wrap-around. I-immediates sign-extended. Shift amount is the low 5 bits. SRL/SRLI zero-fill, SRA/SRAI sign-fill. SLT signed, SLTU unsigned, both yield 0/1. SLTIU compares against the sign-extended immediate as unsigned.
- Forwarding: if the ID-stage rs1/rs2 equals the EX-stage rd (rd≠0, write enabled), ID uses the EX result. Back-to-back dependencies run without stalls.
- Halt: decoding an illegal instruction latches the flag and freezes the PC. The illegal instruction and everything fetched after it are squashed. Older instructions complete. The flag clears only on reset.

## Timing
- Reset (rstn_i low at an edge): PC=BOOT_ADDR, all stage-valid bits 0, flag 0, regfile 0.
- Cycle c (first cycle with rstn_i high): instr_addr_o=BOOT_ADDR. PC advances by 4 each cycle while not halted.
- An address issued in cycle c returns its word in c+1; decode registers at end of c+1; EX computes in c+2; writeback occurs at the edge ending c+2, visible in c+3.
- The word arriving in the first cycle after reset release is invalid unless the fetch-valid bit is set; no decode occurs from it.
- Illegal decoded at end of c+1: flag high from c+2. instr_addr_o holds its value from c+2 onward. No writeback from the squashed slots.
- Reset asserted mid-program: next edge restores reset state and discards in-flight instructions.

## Test plan
- Shift chain: ADDI x1,x0,64; SRLI x2,x1,1; SRLI x2,x2,2; SRLI x3,x2,3; then 0x00000000. Run until flag plus 3 cycles -> x3=1, x1=64, flag=1.
- Back-to-back forwarding: ADDI x1,x0,5; ADDI x1,x1,7; ADD x2,x1,x1 -> x1=12, x2=24.
- Signed ops: ADDI x1,x0,-16; SRAI x2,x1,2; SRLI x3,x1,28; SLTI x4,x1,0; SLTIU x5,x1,1 -> x2=0xFFFFFFFC, x3=0xF, x4=1, x5=0.
- x0/LUI: LUI x0,0x12345; LUI x6,0xABCDE; ORI x6,x6,0x123 -> x0=0, x6=0xABCDE123.
- Illegal halt: ADDI x1,x0,1; word 0xFFFFFFFF; ADDI x1,x0,2 -> x1=1, flag set, instr_addr_o frozen, data_we_o=0 throughout.
- Reset mid-run: assert rstn_i low for 1 cycle during the shift chain -> regs 0, fetch restarts at BOOT_ADDR, final x3=1.
